// File: rtl/axi_mem_tester.sv
// AXI4 memory tester: writes a pattern to NUM_WORDS consecutive words, reads them back
// and reports mismatches, error responses and handshake timeouts.
module axi_mem_tester #(
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
  parameter int          NUM_WORDS = 16,
  parameter int          MODE      = 0,
  parameter logic [31:0] SEED      = 32'hAAAA_5555,
  parameter int          TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [31:0] first_err_addr,
  output logic [7:0]  led
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FINISH} state_t;

  localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_idx;
  logic [31:0] r_wait;
  logic        r_aw_done, r_w_done;
  logic [15:0] r_err_count;
  logic [31:0] r_first_err_addr;
  logic        r_done, r_pass, r_timeout;
  logic        r_wr_done, r_rd_done, r_berr, r_rerr;

  logic [31:0] w_addr, w_pattern;
  logic        w_aw_hs, w_w_hs, w_to_hit, w_pass_now;
  logic        w_err, w_berr, w_rerr, w_idx_inc, w_idx_clr;
  logic        w_wr_last, w_rd_last, w_to, w_run_start;

  assign w_addr     = BASE_ADDR + {14'd0, r_idx, 2'b00};
  assign w_to_hit   = (r_wait == TO_LAST);
  assign w_pass_now = (r_err_count == 16'd0) && !r_timeout;

  always_comb begin
    case (MODE)
      1:       w_pattern = ~w_addr;
      2:       w_pattern = SEED;
      default: w_pattern = w_addr;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_err         = 1'b0;
    w_berr        = 1'b0;
    w_rerr        = 1'b0;
    w_idx_inc     = 1'b0;
    w_idx_clr     = 1'b0;
    w_wr_last     = 1'b0;
    w_rd_last     = 1'b0;
    w_to          = 1'b0;
    w_run_start   = 1'b0;
    m_axi_awvalid = (r_state == WR_REQ) && !r_aw_done;
    m_axi_wvalid  = (r_state == WR_REQ) && !r_w_done;
    m_axi_bready  = (r_state == WR_RESP);
    m_axi_arvalid = (r_state == RD_REQ);
    m_axi_rready  = (r_state == RD_RESP);
    m_axi_awaddr  = m_axi_awvalid ? w_addr : 32'd0;
    m_axi_wdata   = m_axi_wvalid ? w_pattern : 32'd0;
    m_axi_wstrb   = m_axi_wvalid ? 4'b1111 : 4'b0000;
    m_axi_araddr  = m_axi_arvalid ? w_addr : 32'd0;
    w_aw_hs       = m_axi_awvalid && m_axi_awready;
    w_w_hs        = m_axi_wvalid && m_axi_wready;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_run_start = 1'b1;
          w_state_nxt = WR_REQ;
        end
      end
      WR_REQ: begin
        // Address and data may complete in either order or together.
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          w_state_nxt = WR_RESP;
        end else if (w_to_hit) begin
          w_to        = 1'b1;
          w_state_nxt = FINISH;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) begin
            w_err  = 1'b1;
            w_berr = 1'b1;
          end
          if (r_idx == LAST_IDX) begin
            w_idx_clr   = 1'b1;
            w_wr_last   = 1'b1;
            w_state_nxt = RD_REQ;
          end else begin
            w_idx_inc   = 1'b1;
            w_state_nxt = WR_REQ;
          end
        end else if (w_to_hit) begin
          w_to        = 1'b1;
          w_state_nxt = FINISH;
        end
      end
      RD_REQ: begin
        if (m_axi_arready) begin
          w_state_nxt = RD_RESP;
        end else if (w_to_hit) begin
          w_to        = 1'b1;
          w_state_nxt = FINISH;
        end
      end
      RD_RESP: begin
        if (m_axi_rvalid) begin
          w_rerr = (m_axi_rresp != 2'b00);
          w_err  = (m_axi_rdata != w_pattern) || (m_axi_rresp != 2'b00);
          if (r_idx == LAST_IDX) begin
            w_rd_last   = 1'b1;
            w_state_nxt = FINISH;
          end else begin
            w_idx_inc   = 1'b1;
            w_state_nxt = RD_REQ;
          end
        end else if (w_to_hit) begin
          w_to        = 1'b1;
          w_state_nxt = FINISH;
        end
      end
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx            <= 16'd0;
      r_wait           <= 32'd0;
      r_aw_done        <= 1'b0;
      r_w_done         <= 1'b0;
      r_err_count      <= 16'd0;
      r_first_err_addr <= 32'd0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_timeout        <= 1'b0;
      r_wr_done        <= 1'b0;
      r_rd_done        <= 1'b0;
      r_berr           <= 1'b0;
      r_rerr           <= 1'b0;
    end else begin
      // The wait counter only runs while parked in one waiting state.
      if ((w_state_nxt != r_state) || (r_state == IDLE) || (r_state == FINISH))
        r_wait <= 32'd0;
      else
        r_wait <= r_wait + 32'd1;
      r_aw_done <= (r_state == WR_REQ && w_state_nxt == WR_REQ) ? (r_aw_done || w_aw_hs) : 1'b0;
      r_w_done  <= (r_state == WR_REQ && w_state_nxt == WR_REQ) ? (r_w_done || w_w_hs) : 1'b0;
      if (w_run_start) begin
        r_idx            <= 16'd0;
        r_err_count      <= 16'd0;
        r_first_err_addr <= 32'd0;
        r_done           <= 1'b0;
        r_pass           <= 1'b0;
        r_timeout        <= 1'b0;
        r_wr_done        <= 1'b0;
        r_rd_done        <= 1'b0;
        r_berr           <= 1'b0;
        r_rerr           <= 1'b0;
      end else begin
        if (w_idx_clr)      r_idx <= 16'd0;
        else if (w_idx_inc) r_idx <= r_idx + 16'd1;
        if (w_err) begin
          if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
          if (r_err_count == 16'd0)    r_first_err_addr <= w_addr;
        end
        if (w_berr)    r_berr    <= 1'b1;
        if (w_rerr)    r_rerr    <= 1'b1;
        if (w_wr_last) r_wr_done <= 1'b1;
        if (w_rd_last) r_rd_done <= 1'b1;
        if (w_to)      r_timeout <= 1'b1;
        if (r_state == FINISH) begin
          r_done <= 1'b1;
          r_pass <= w_pass_now;
        end
      end
    end
  end

  assign busy           = (r_state != IDLE) && (r_state != FINISH);
  assign done           = r_done || (r_state == FINISH);
  assign pass           = (r_state == FINISH) ? w_pass_now : r_pass;
  assign err_count      = r_err_count;
  assign first_err_addr = r_first_err_addr;
  assign led            = {done, busy, r_rerr, r_berr, r_timeout, pass, r_rd_done, r_wr_done};

endmodule

// File: tb/tb_axi_mem_tester.sv
// Bench for axi_mem_tester: three configurations, each driven by a configurable AXI slave
// with an ideal memory, checked against a word-level reference model.
module tb_axi_mem_tester;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic        start [N];
  logic [31:0] awaddr [N];
  logic        awvalid [N], awready [N];
  logic [31:0] wdata [N];
  logic [3:0]  wstrb [N];
  logic        wvalid [N], wready [N];
  logic [1:0]  bresp [N];
  logic        bvalid [N], bready [N];
  logic [31:0] araddr [N];
  logic        arvalid [N], arready [N];
  logic [31:0] rdata [N];
  logic [1:0]  rresp [N];
  logic        rvalid [N], rready [N];
  logic        busy [N], done [N], pass [N];
  logic [15:0] errc [N];
  logic [31:0] fea [N];
  logic [7:0]  led [N];

  int   aw_dly [N], w_dly [N], b_dly [N], ar_dly [N], r_dly [N];
  bit   ar_never [N];
  logic [1:0] bresp_w [N][16];
  logic [1:0] rresp_w [N][16];
  bit   corrupt_w [N][16];

  logic [31:0] mem [N][16];
  logic [31:0] aw_log [N][16];
  int   aw_cnt [N], w_cnt [N], ar_cnt [N], b_cnt [N], r_cnt [N];
  logic got_aw [N], got_w [N], b_pend [N], r_pend [N];
  logic [31:0] cap_addr [N], cap_data [N], b_addr [N], r_addr [N];
  int   n_aw [N], n_w [N], n_b [N], n_ar [N], n_r [N], viol [N], bad_strb [N];
  int   ar_run [N], ar_run_max [N];
  logic p_awv [N], p_awr [N], p_wv [N], p_wr [N], p_arv [N], p_arr [N];
  logic [31:0] p_awa [N], p_wd [N], p_ara [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_mem_tester #(.BASE_ADDR(32'h0100_0000), .NUM_WORDS(4), .MODE(0), .TIMEOUT(16)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]),
    .m_axi_awaddr(awaddr[0]), .m_axi_awvalid(awvalid[0]), .m_axi_awready(awready[0]),
    .m_axi_wdata(wdata[0]), .m_axi_wstrb(wstrb[0]), .m_axi_wvalid(wvalid[0]), .m_axi_wready(wready[0]),
    .m_axi_bresp(bresp[0]), .m_axi_bvalid(bvalid[0]), .m_axi_bready(bready[0]),
    .m_axi_araddr(araddr[0]), .m_axi_arvalid(arvalid[0]), .m_axi_arready(arready[0]),
    .m_axi_rdata(rdata[0]), .m_axi_rresp(rresp[0]), .m_axi_rvalid(rvalid[0]), .m_axi_rready(rready[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]),
    .first_err_addr(fea[0]), .led(led[0]));

  axi_mem_tester #(.BASE_ADDR(32'h0100_0000), .NUM_WORDS(3), .MODE(1), .TIMEOUT(16)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]),
    .m_axi_awaddr(awaddr[1]), .m_axi_awvalid(awvalid[1]), .m_axi_awready(awready[1]),
    .m_axi_wdata(wdata[1]), .m_axi_wstrb(wstrb[1]), .m_axi_wvalid(wvalid[1]), .m_axi_wready(wready[1]),
    .m_axi_bresp(bresp[1]), .m_axi_bvalid(bvalid[1]), .m_axi_bready(bready[1]),
    .m_axi_araddr(araddr[1]), .m_axi_arvalid(arvalid[1]), .m_axi_arready(arready[1]),
    .m_axi_rdata(rdata[1]), .m_axi_rresp(rresp[1]), .m_axi_rvalid(rvalid[1]), .m_axi_rready(rready[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]),
    .first_err_addr(fea[1]), .led(led[1]));

  axi_mem_tester #(.BASE_ADDR(32'hFFFF_FFF8), .NUM_WORDS(5), .MODE(2), .SEED(32'h1234_5678),
                   .TIMEOUT(16)) dut2 (
    .clk(clk), .rst(rst), .start(start[2]),
    .m_axi_awaddr(awaddr[2]), .m_axi_awvalid(awvalid[2]), .m_axi_awready(awready[2]),
    .m_axi_wdata(wdata[2]), .m_axi_wstrb(wstrb[2]), .m_axi_wvalid(wvalid[2]), .m_axi_wready(wready[2]),
    .m_axi_bresp(bresp[2]), .m_axi_bvalid(bvalid[2]), .m_axi_bready(bready[2]),
    .m_axi_araddr(araddr[2]), .m_axi_arvalid(arvalid[2]), .m_axi_arready(arready[2]),
    .m_axi_rdata(rdata[2]), .m_axi_rresp(rresp[2]), .m_axi_rvalid(rvalid[2]), .m_axi_rready(rready[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(errc[2]),
    .first_err_addr(fea[2]), .led(led[2]));

  function automatic logic [31:0] base_of(int k);
    return (k == 2) ? 32'hFFFF_FFF8 : 32'h0100_0000;
  endfunction
  function automatic int nw_of(int k);
    return (k == 0) ? 4 : (k == 1) ? 3 : 5;
  endfunction
  function automatic logic [31:0] addr_of(int k, int i);
    return base_of(k) + 32'(4 * i);
  endfunction
  function automatic logic [31:0] pat_of(int k, int i);
    if (k == 0) return addr_of(k, i);
    if (k == 1) return ~addr_of(k, i);
    return 32'h1234_5678;
  endfunction
  function automatic int widx(int k, logic [31:0] a);
    logic [31:0] d;
    d = a - base_of(k);
    return int'(d[5:2]);
  endfunction

  // Slave handshake/response side: readies and responses follow the per-run knobs.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      awready[k] = awvalid[k] && (aw_cnt[k] >= aw_dly[k]);
      wready[k]  = wvalid[k] && (w_cnt[k] >= w_dly[k]);
      arready[k] = arvalid[k] && !ar_never[k] && (ar_cnt[k] >= ar_dly[k]);
      bvalid[k]  = b_pend[k] && (b_cnt[k] >= b_dly[k]);
      bresp[k]   = bvalid[k] ? bresp_w[k][widx(k, b_addr[k])] : 2'b00;
      rvalid[k]  = r_pend[k] && (r_cnt[k] >= r_dly[k]);
      rdata[k]   = rvalid[k] ? (mem[k][widx(k, r_addr[k])] ^ {31'd0, corrupt_w[k][widx(k, r_addr[k])]})
                             : 32'd0;
      rresp[k]   = rvalid[k] ? rresp_w[k][widx(k, r_addr[k])] : 2'b00;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (rst || clr) begin
        aw_cnt[k] <= 0; w_cnt[k] <= 0; ar_cnt[k] <= 0; b_cnt[k] <= 0; r_cnt[k] <= 0;
        got_aw[k] <= 1'b0; got_w[k] <= 1'b0; b_pend[k] <= 1'b0; r_pend[k] <= 1'b0;
        cap_addr[k] <= 32'd0; cap_data[k] <= 32'd0; b_addr[k] <= 32'd0; r_addr[k] <= 32'd0;
        n_aw[k] <= 0; n_w[k] <= 0; n_b[k] <= 0; n_ar[k] <= 0; n_r[k] <= 0;
        viol[k] <= 0; bad_strb[k] <= 0; ar_run[k] <= 0; ar_run_max[k] <= 0;
        p_awv[k] <= 1'b0; p_awr[k] <= 1'b0; p_wv[k] <= 1'b0; p_wr[k] <= 1'b0;
        p_arv[k] <= 1'b0; p_arr[k] <= 1'b0;
        p_awa[k] <= 32'd0; p_wd[k] <= 32'd0; p_ara[k] <= 32'd0;
      end else begin
        aw_cnt[k] <= (awvalid[k] && !awready[k]) ? aw_cnt[k] + 1 : 0;
        w_cnt[k]  <= (wvalid[k] && !wready[k]) ? w_cnt[k] + 1 : 0;
        ar_cnt[k] <= (arvalid[k] && !arready[k]) ? ar_cnt[k] + 1 : 0;
        if (awvalid[k] && awready[k]) begin
          cap_addr[k] <= awaddr[k];
          got_aw[k]   <= 1'b1;
          aw_log[k][n_aw[k] & 15] <= awaddr[k];
          n_aw[k]     <= n_aw[k] + 1;
        end
        if (wvalid[k] && wready[k]) begin
          cap_data[k] <= wdata[k];
          got_w[k]    <= 1'b1;
          n_w[k]      <= n_w[k] + 1;
          if (wstrb[k] != 4'hF) bad_strb[k] <= bad_strb[k] + 1;
        end
        if (b_pend[k]) begin
          if (bvalid[k] && bready[k]) begin
            b_pend[k] <= 1'b0;
            n_b[k]    <= n_b[k] + 1;
          end else begin
            b_cnt[k] <= b_cnt[k] + 1;
          end
        end
        if ((got_aw[k] || (awvalid[k] && awready[k])) && (got_w[k] || (wvalid[k] && wready[k]))) begin
          mem[k][widx(k, (awvalid[k] && awready[k]) ? awaddr[k] : cap_addr[k])] <=
            (wvalid[k] && wready[k]) ? wdata[k] : cap_data[k];
          b_addr[k] <= (awvalid[k] && awready[k]) ? awaddr[k] : cap_addr[k];
          b_pend[k] <= 1'b1;
          b_cnt[k]  <= 0;
          got_aw[k] <= 1'b0;
          got_w[k]  <= 1'b0;
        end
        if (r_pend[k]) begin
          if (rvalid[k] && rready[k]) begin
            r_pend[k] <= 1'b0;
            n_r[k]    <= n_r[k] + 1;
          end else begin
            r_cnt[k] <= r_cnt[k] + 1;
          end
        end
        if (arvalid[k] && arready[k]) begin
          r_pend[k] <= 1'b1;
          r_addr[k] <= araddr[k];
          r_cnt[k]  <= 0;
          n_ar[k]   <= n_ar[k] + 1;
        end
        if ((p_awv[k] && p_awr[k] && awvalid[k]) ||
            (p_awv[k] && !p_awr[k] && (!awvalid[k] || awaddr[k] != p_awa[k])) ||
            (p_wv[k] && p_wr[k] && wvalid[k]) ||
            (p_wv[k] && !p_wr[k] && (!wvalid[k] || wdata[k] != p_wd[k])) ||
            (p_arv[k] && p_arr[k] && arvalid[k]) ||
            (p_arv[k] && !p_arr[k] && arvalid[k] && araddr[k] != p_ara[k]))
          viol[k] <= viol[k] + 1;
        if (arvalid[k]) begin
          ar_run[k] <= ar_run[k] + 1;
          if (ar_run[k] + 1 > ar_run_max[k]) ar_run_max[k] <= ar_run[k] + 1;
        end else begin
          ar_run[k] <= 0;
        end
        p_awv[k] <= awvalid[k]; p_awr[k] <= awready[k]; p_awa[k] <= awaddr[k];
        p_wv[k]  <= wvalid[k];  p_wr[k]  <= wready[k];  p_wd[k]  <= wdata[k];
        p_arv[k] <= arvalid[k]; p_arr[k] <= arready[k]; p_ara[k] <= araddr[k];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_knobs(input int k);
    aw_dly[k] = 0; w_dly[k] = 0; b_dly[k] = 0; ar_dly[k] = 0; r_dly[k] = 0;
    ar_never[k] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bresp_w[k][i] = 2'b00;
      rresp_w[k][i] = 2'b00;
      corrupt_w[k][i] = 1'b0;
    end
  endtask

  task automatic check_zero(input int k, input string tag);
    chk($sformatf("%s_ctl%0d", tag, k),
        {24'd0, awvalid[k], wvalid[k], bready[k], arvalid[k], rready[k], busy[k], done[k], pass[k]}, 32'd0);
    chk($sformatf("%s_awaddr%0d", tag, k), awaddr[k], 32'd0);
    chk($sformatf("%s_wdata%0d", tag, k), wdata[k], 32'd0);
    chk($sformatf("%s_wstrb%0d", tag, k), {28'd0, wstrb[k]}, 32'd0);
    chk($sformatf("%s_araddr%0d", tag, k), araddr[k], 32'd0);
    chk($sformatf("%s_errc%0d", tag, k), {16'd0, errc[k]}, 32'd0);
    chk($sformatf("%s_fea%0d", tag, k), fea[k], 32'd0);
    chk($sformatf("%s_led%0d", tag, k), {24'd0, led[k]}, 32'd0);
  endtask

  // Expected results from the word-level rules: write errors first, then read errors.
  task automatic model(input int k, input bit to, output logic [15:0] e, output logic [31:0] f,
                       output logic [7:0] l, output logic p);
    bit bw, br;
    e = 16'd0; f = 32'd0; bw = 1'b0; br = 1'b0;
    for (int i = 0; i < nw_of(k); i++) begin
      if (bresp_w[k][i] != 2'b00) begin
        bw = 1'b1;
        if (e == 16'd0) f = addr_of(k, i);
        e++;
      end
    end
    if (!to) begin
      for (int i = 0; i < nw_of(k); i++) begin
        if (rresp_w[k][i] != 2'b00) br = 1'b1;
        if (corrupt_w[k][i] || rresp_w[k][i] != 2'b00) begin
          if (e == 16'd0) f = addr_of(k, i);
          e++;
        end
      end
    end
    p = (e == 16'd0) && !to;
    l = {1'b1, 1'b0, br, bw, to, p, !to, 1'b1};
  endtask

  task automatic run(input int k, input bit to, input bit extra_start, input string tag);
    bit ok;
    logic [15:0] e;
    logic [31:0] f;
    logic [7:0]  l;
    logic        p;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    start[k] = 1'b1;
    tick(1);
    start[k] = 1'b0;
    if (extra_start) begin
      tick(2);
      start[k] = 1'b1;
      tick(1);
      start[k] = 1'b0;
    end
    ok = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (done[k]) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    chk($sformatf("%s_done_seen", tag), {31'd0, ok}, 32'd1);
    if (ok) begin
      model(k, to, e, f, l, p);
      chk($sformatf("%s_pass_finish", tag), {31'd0, pass[k]}, {31'd0, p});
      chk($sformatf("%s_busy_finish", tag), {31'd0, busy[k]}, 32'd0);
      tick(2);
      chk($sformatf("%s_done_held", tag), {31'd0, done[k]}, 32'd1);
      chk($sformatf("%s_pass_held", tag), {31'd0, pass[k]}, {31'd0, p});
      chk($sformatf("%s_errc", tag), {16'd0, errc[k]}, {16'd0, e});
      chk($sformatf("%s_fea", tag), fea[k], f);
      chk($sformatf("%s_led", tag), {24'd0, led[k]}, {24'd0, l});
      chk($sformatf("%s_n_aw", tag), n_aw[k], nw_of(k));
      chk($sformatf("%s_n_w", tag), n_w[k], nw_of(k));
      chk($sformatf("%s_n_b", tag), n_b[k], nw_of(k));
      chk($sformatf("%s_n_ar", tag), n_ar[k], to ? 0 : nw_of(k));
      chk($sformatf("%s_n_r", tag), n_r[k], to ? 0 : nw_of(k));
      chk($sformatf("%s_viol", tag), viol[k], 0);
      chk($sformatf("%s_strb", tag), bad_strb[k], 0);
      for (int i = 0; i < nw_of(k); i++) begin
        chk($sformatf("%s_awaddr_w%0d", tag, i), aw_log[k][i], addr_of(k, i));
        chk($sformatf("%s_mem_w%0d", tag, i), mem[k][i], pat_of(k, i));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    for (int k = 0; k < N; k++) begin
      start[k] = 1'b0;
      clear_knobs(k);
    end
    tick(3);
    for (int k = 0; k < N; k++) check_zero(k, "reset");
    rst = 1'b0;
    tick(5);
    for (int k = 0; k < N; k++)
      chk($sformatf("idle_after_reset%0d", k), {30'd0, busy[k], done[k]}, 32'd0);

    run(0, 1'b0, 1'b0, "zero_lat");
    chk("zero_lat_led87", {24'd0, led[0]}, 32'h87);
    chk("zero_lat_pass", {31'd0, pass[0]}, 32'd1);

    clear_knobs(0);
    aw_dly[0] = 3;
    run(0, 1'b0, 1'b1, "w_before_aw");

    clear_knobs(1);
    corrupt_w[1][2] = 1'b1;
    run(1, 1'b0, 1'b0, "corrupt2");
    chk("corrupt2_errc", {16'd0, errc[1]}, 32'd1);
    chk("corrupt2_fea", fea[1], 32'h0100_0008);

    clear_knobs(0);
    ar_never[0] = 1'b1;
    run(0, 1'b1, 1'b0, "ar_timeout");
    chk("ar_timeout_arvalid_cycles", ar_run_max[0], 16);
    chk("ar_timeout_led3", {31'd0, led[0][3]}, 32'd1);

    clear_knobs(1);
    for (int i = 0; i < 3; i++) bresp_w[1][i] = 2'b10;
    run(1, 1'b0, 1'b0, "bresp_err");
    chk("bresp_err_errc", {16'd0, errc[1]}, 32'd3);
    chk("bresp_err_led4", {31'd0, led[1][4]}, 32'd1);

    clear_knobs(2);
    run(2, 1'b0, 1'b0, "wrap_seed");

    for (int it = 0; it < 9; it++) begin
      int k;
      k = it % N;
      clear_knobs(k);
      aw_dly[k] = $urandom_range(0, 5);
      w_dly[k]  = $urandom_range(0, 5);
      b_dly[k]  = $urandom_range(0, 5);
      ar_dly[k] = $urandom_range(0, 5);
      r_dly[k]  = $urandom_range(0, 5);
      for (int i = 0; i < 16; i++) begin
        bresp_w[k][i]   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        rresp_w[k][i]   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        corrupt_w[k][i] = ($urandom_range(0, 4) == 0);
      end
      run(k, 1'b0, 1'b0, $sformatf("rand%0d", it));
    end

    clear_knobs(0);
    aw_dly[0] = 5;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    tick(1);
    chk("midrun_awvalid", {31'd0, awvalid[0]}, 32'd1);
    rst = 1'b1;
    #1;
    check_zero(0, "midrun_rst");
    tick(2);
    check_zero(0, "midrun_rst_hold");
    rst = 1'b0;
    tick(4);
    chk("midrun_idle", {30'd0, busy[0], done[0]}, 32'd0);
    clear_knobs(0);
    run(0, 1'b0, 1'b0, "after_rst");
    chk("after_rst_pass", {31'd0, pass[0]}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
